// File: rtl/lc3_mmio_ctl.sv
// LC-3 memory-access controller: steers MAR accesses to RAM or to the on-chip
// keyboard/display/machine-control registers and returns one ready strobe.
module lc3_mmio_ctl #(
   parameter logic [6:0] DEV_BASE = 7'h7F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MIO_EN,
   input  logic        RW,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic [15:0] mem_rdata,
   input  logic        mem_R,
   output logic        MEM_EN,
   output logic [15:0] rdata,
   output logic        R,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   output logic        disp_valid,
   output logic [7:0]  disp_data,
   input  logic        disp_ready,
   output logic        kb_irq,
   output logic        disp_irq,
   output logic        run
);

   typedef enum logic [1:0] {IDLE, DEV_ACK, MEM_WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic        rw_q, rw_d;
   logic [15:0] rdata_q, rdata_d;
   logic        kb_rdy_q, kb_rdy_d, kb_ie_q, kb_ie_d, kb_ovr_q, kb_ovr_d;
   logic [7:0]  kbdr_q, kbdr_d;
   logic        dsr_rdy_q, dsr_rdy_d, dsr_ie_q, dsr_ie_d;
   logic        disp_valid_q, disp_valid_d;
   logic [7:0]  disp_data_q, disp_data_d;
   logic [15:0] mcr_q, mcr_d;

   logic        is_dev, accept, dev_rd, dev_wr, kbdr_rd;
   logic        sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr;
   logic [15:0] dev_rdata;

   assign is_dev   = (MAR[15:9] == DEV_BASE);
   assign accept   = (state_q == IDLE) && MIO_EN;
   assign dev_rd   = accept && is_dev && !RW;
   assign dev_wr   = accept && is_dev && RW;
   assign sel_kbsr = (MAR[8:0] == 9'h000);
   assign sel_kbdr = (MAR[8:0] == 9'h002);
   assign sel_dsr  = (MAR[8:0] == 9'h004);
   assign sel_ddr  = (MAR[8:0] == 9'h006);
   assign sel_mcr  = (MAR[8:0] == 9'h1FE);
   assign kbdr_rd  = dev_rd && sel_kbdr;

   always_comb begin
      dev_rdata = 16'h0000;
      if (sel_kbsr)      dev_rdata = {kb_rdy_q, kb_ie_q, kb_ovr_q, 13'h0000};
      else if (sel_kbdr) dev_rdata = {8'h00, kbdr_q};
      else if (sel_dsr)  dev_rdata = {dsr_rdy_q, dsr_ie_q, 14'h0000};
      else if (sel_ddr)  dev_rdata = {8'h00, disp_data_q};
      else if (sel_mcr)  dev_rdata = mcr_q;
   end

   always_comb begin
      state_d      = state_q;
      rw_d         = rw_q;
      rdata_d      = rdata_q;
      kb_rdy_d     = kb_rdy_q;
      kb_ie_d      = kb_ie_q;
      kb_ovr_d     = kb_ovr_q;
      kbdr_d       = kbdr_q;
      dsr_rdy_d    = dsr_rdy_q;
      dsr_ie_d     = dsr_ie_q;
      disp_valid_d = disp_valid_q;
      disp_data_d  = disp_data_q;
      mcr_d        = mcr_q;

      unique case (state_q)
         IDLE:     if (MIO_EN) begin
                      state_d = is_dev ? DEV_ACK : MEM_WAIT;
                      rw_d    = RW;
                   end
         DEV_ACK:  state_d = DONE;
         MEM_WAIT: if (mem_R) state_d = DONE;
         DONE:     if (!MIO_EN) state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      if (dev_rd)
         rdata_d = dev_rdata;
      else if ((state_q == MEM_WAIT) && mem_R && !rw_q)
         rdata_d = mem_rdata;

      // Keyboard: a KBDR read on the same edge frees the buffer, so the new
      // character is taken rather than counted as an overrun.
      if (kbdr_rd) kb_rdy_d = 1'b0;
      if (dev_wr && sel_kbsr) begin
         kb_ie_d  = MDR[14];
         kb_ovr_d = 1'b0;
      end
      if (kb_valid) begin
         if (!kb_rdy_q || kbdr_rd) begin
            kbdr_d   = kb_data;
            kb_rdy_d = 1'b1;
         end else begin
            kb_ovr_d = 1'b1;
         end
      end

      if (dev_wr && sel_dsr) dsr_ie_d = MDR[14];
      if (dev_wr && sel_ddr && dsr_rdy_q) begin
         disp_data_d  = MDR[7:0];
         dsr_rdy_d    = 1'b0;
         disp_valid_d = 1'b1;
      end else if (disp_valid_q && disp_ready) begin
         disp_valid_d = 1'b0;
         dsr_rdy_d    = 1'b1;
      end

      if (dev_wr && sel_mcr) mcr_d = MDR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         rdata_q      <= 16'h0000;
         kb_rdy_q     <= 1'b0;
         kb_ie_q      <= 1'b0;
         kb_ovr_q     <= 1'b0;
         kbdr_q       <= 8'h00;
         dsr_rdy_q    <= 1'b1;
         dsr_ie_q     <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= 8'h00;
         mcr_q        <= 16'h8000;
      end else begin
         state_q      <= state_d;
         rw_q         <= rw_d;
         rdata_q      <= rdata_d;
         kb_rdy_q     <= kb_rdy_d;
         kb_ie_q      <= kb_ie_d;
         kb_ovr_q     <= kb_ovr_d;
         kbdr_q       <= kbdr_d;
         dsr_rdy_q    <= dsr_rdy_d;
         dsr_ie_q     <= dsr_ie_d;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
         mcr_q        <= mcr_d;
      end
   end

   // Strobes are gated by reset so an aborted access never reports completion.
   assign R          = !reset && ((state_q == DEV_ACK) || ((state_q == MEM_WAIT) && mem_R));
   assign MEM_EN     = !reset && MIO_EN &&
                       (((state_q == IDLE) && !is_dev) || (state_q == MEM_WAIT));
   assign rdata      = rdata_q;
   assign disp_valid = disp_valid_q;
   assign disp_data  = disp_data_q;
   assign kb_irq     = kb_rdy_q && kb_ie_q;
   assign disp_irq   = dsr_rdy_q && dsr_ie_q;
   assign run        = mcr_q[15];

endmodule

// File: tb/tb_lc3_mmio_ctl.sv
// Scoreboarded bench for lc3_mmio_ctl: expected read words are queued when an
// access is issued and compared when the controller returns its ready strobe.
module tb_lc3_mmio_ctl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MIO_EN = 1'b0, RW = 1'b0;
   logic [15:0] MAR = 16'h0000, MDR = 16'h0000, mem_rdata = 16'h0000;
   logic        mem_R = 1'b0;
   logic        MEM_EN;
   logic [15:0] rdata;
   logic        R;
   logic        kb_valid = 1'b0;
   logic [7:0]  kb_data = 8'h00;
   logic        disp_valid;
   logic [7:0]  disp_data;
   logic        disp_ready = 1'b0;
   logic        kb_irq, disp_irq, run;

   int n_vec  = 0;
   int n_miss = 0;
   logic [15:0] exp_q[$];

   lc3_mmio_ctl #(.DEV_BASE(7'h7F)) dut (
      .clk(clk), .reset(reset), .MIO_EN(MIO_EN), .RW(RW), .MAR(MAR), .MDR(MDR),
      .mem_rdata(mem_rdata), .mem_R(mem_R), .MEM_EN(MEM_EN), .rdata(rdata), .R(R),
      .kb_valid(kb_valid), .kb_data(kb_data), .disp_valid(disp_valid),
      .disp_data(disp_data), .disp_ready(disp_ready), .kb_irq(kb_irq),
      .disp_irq(disp_irq), .run(run)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // One complete access. mem_lat is the cycle (counted from MIO_EN rise) in
   // which the RAM model raises mem_R; kb_ch >= 0 strobes a key on the accept edge.
   task automatic access(input string tag, input logic rw, input logic [15:0] addr,
                         input logic [15:0] wdata, input int mem_lat,
                         input logic [15:0] mem_word, input int kb_ch);
      int cyc, memen, rcyc;
      bit got, dev;
      dev = (addr[15:9] == 7'h7F);
      @(posedge clk); #1;
      MIO_EN = 1'b1; RW = rw; MAR = addr; MDR = wdata; mem_rdata = mem_word;
      if (kb_ch >= 0) begin kb_valid = 1'b1; kb_data = 8'(kb_ch); end
      cyc = 0; memen = 0; rcyc = -1; got = 1'b0;
      while (!got && cyc < 20) begin
         mem_R = (mem_lat > 0 && cyc == mem_lat);
         @(negedge clk);
         if (MEM_EN) memen++;
         if (R) begin got = 1'b1; rcyc = cyc; end
         @(posedge clk); #1;
         cyc++;
         kb_valid = 1'b0;
         // Disturb address/direction after acceptance; the decode must be latched.
         if (!dev) begin MAR = 16'hFE00; RW = ~rw; end
      end
      mem_R = 1'b0;
      check({tag, " R seen"}, 16'(got), 16'd1);
      check({tag, " R latency"}, 16'(rcyc), dev ? 16'd1 : 16'(mem_lat));
      @(negedge clk);
      if (MEM_EN) memen++;
      check({tag, " R one pulse"}, 16'(R), 16'd0);
      check({tag, " MEM_EN cycles"}, 16'(memen), dev ? 16'd0 : 16'(mem_lat + 1));
      if (!rw) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s scoreboard: got %h expected <empty queue>", tag, rdata);
         end else begin
            check({tag, " rdata"}, rdata, exp_q.pop_front());
         end
      end
      @(posedge clk); #1;
      MIO_EN = 1'b0; RW = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      exp_q.push_back(exp);
      access(tag, 1'b0, addr, 16'h0000, 0, 16'hDEAD, -1);
   endtask

   task automatic wr(input string tag, input logic [15:0] addr, input logic [15:0] data);
      access(tag, 1'b1, addr, data, 0, 16'hDEAD, -1);
   endtask

   task automatic kb_pulse(input logic [7:0] ch);
      @(posedge clk); #1;
      kb_valid = 1'b1; kb_data = ch;
      @(posedge clk); #1;
      kb_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst R", 16'(R), 16'd0);
      check("rst MEM_EN", 16'(MEM_EN), 16'd0);
      check("rst rdata", rdata, 16'h0000);
      check("rst disp_valid", 16'(disp_valid), 16'd0);
      check("rst disp_data", 16'(disp_data), 16'h0000);
      check("rst run", 16'(run), 16'd1);
      check("rst irqs", {14'd0, kb_irq, disp_irq}, 16'd0);

      rd("DSR rd", 16'hFE04, 16'h8000);
      rd("MCR rd", 16'hFFFE, 16'h8000);
      check("run after MCR rd", 16'(run), 16'd1);

      kb_pulse(8'h41);
      rd("KBSR full", 16'hFE00, 16'h8000);
      rd("KBDR rd", 16'hFE02, 16'h0041);
      rd("KBSR empty", 16'hFE00, 16'h0000);

      kb_pulse(8'h41);
      kb_pulse(8'h42);
      rd("KBSR overrun", 16'hFE00, 16'hA000);
      wr("KBSR wr", 16'hFE00, 16'h4000);
      rd("KBSR ie", 16'hFE00, 16'hC000);
      check("kb_irq on", 16'(kb_irq), 16'd1);
      rd("KBDR kept", 16'hFE02, 16'h0041);
      rd("KBSR ie only", 16'hFE00, 16'h4000);
      check("kb_irq off", 16'(kb_irq), 16'd0);

      kb_pulse(8'h43);
      exp_q.push_back(16'h0043);
      access("KBDR rd+key", 1'b0, 16'hFE02, 16'h0000, 0, 16'hDEAD, 8'h44);
      rd("KBSR set wins", 16'hFE00, 16'hC000);
      rd("KBDR new", 16'hFE02, 16'h0044);
      kb_pulse(8'h45);
      access("KBSR wr+ovr", 1'b1, 16'hFE00, 16'h0000, 0, 16'hDEAD, 8'h46);
      rd("KBSR ovr sticky", 16'hFE00, 16'hA000);
      rd("KBDR 45", 16'hFE02, 16'h0045);

      wr("DDR wr X", 16'hFE06, 16'h0058);
      check("disp_valid up", 16'(disp_valid), 16'd1);
      check("disp_data X", 16'(disp_data), 16'h0058);
      rd("DSR busy", 16'hFE04, 16'h0000);
      wr("DDR wr Y", 16'hFE06, 16'h0059);
      check("disp_data kept", 16'(disp_data), 16'h0058);
      check("disp_valid held", 16'(disp_valid), 16'd1);
      @(posedge clk); #1 disp_ready = 1'b1;
      @(posedge clk); #1 disp_ready = 1'b0;
      @(negedge clk);
      check("disp_valid down", 16'(disp_valid), 16'd0);
      rd("DSR ready", 16'hFE04, 16'h8000);
      wr("DSR wr", 16'hFE04, 16'h4000);
      rd("DSR ie", 16'hFE04, 16'hC000);
      check("disp_irq on", 16'(disp_irq), 16'd1);

      exp_q.push_back(16'hBEEF);
      access("RAM rd", 1'b0, 16'h3000, 16'h0000, 3, 16'hBEEF, -1);
      access("RAM wr", 1'b1, 16'h3002, 16'h1234, 1, 16'h5555, -1);
      rd("unmapped rd", 16'hFE10, 16'h0000);
      wr("unmapped wr", 16'hFE10, 16'hFFFF);
      rd("rd after unmapped", 16'hFE04, 16'hC000);

      wr("MCR wr", 16'hFFFE, 16'h0000);
      check("run halted", 16'(run), 16'd0);
      rd("MCR zero", 16'hFFFE, 16'h0000);

      wr("DDR wr pend", 16'hFE06, 16'h0070);
      check("disp pending", 16'(disp_valid), 16'd1);
      @(posedge clk); #1;
      MIO_EN = 1'b1; RW = 1'b0; MAR = 16'h4000; mem_rdata = 16'h1234;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; mem_R = 1'b1;
      @(negedge clk);
      check("rst-abort R", 16'(R), 16'd0);
      @(posedge clk); #1;
      reset = 1'b0; mem_R = 1'b0; MIO_EN = 1'b0;
      @(negedge clk);
      check("post-rst R", 16'(R), 16'd0);
      check("post-rst run", 16'(run), 16'd1);
      check("post-rst disp_valid", 16'(disp_valid), 16'd0);
      check("post-rst rdata", rdata, 16'h0000);
      rd("post-rst DSR", 16'hFE04, 16'h8000);

      check("scoreboard drained", 16'(exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
